pipeline_hazard_ctrl: RTL and testbench

- Parametrised hazard controller for the 5-stage RISC-V pipeline; successor to the fixed two-operand forwarding logic.
- Adds EX forwarding select, ID-stage forwarding for the decode comparator, load-use and branch-operand stalls, and IF/ID and ID/EX flush generation.
- Adds a multi-cycle data-memory wait FSM and saturating stall/flush performance counters.
- Sits beside the pipeline registers: its outputs drive the PC, IF/ID, ID/EX and EX/MEM write enables, the flushes and the forwarding muxes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects and memory-wait FSM states.
// Pure types and helpers; no logic, no latency.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    // Width of the memory-wait down-counter; never zero so MEM_LAT=0 still elaborates.
    function automatic int lat_cnt_w(input int lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register fields in, enables/flushes/selects out.
// Purely a signal bundle; timing is set by the controller and the pipeline registers.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2;
    logic                  id_uses_rs1, id_uses_rs2;
    logic                  id_is_branch, id_branch_taken;
    logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic                  ex_regwrite, ex_memread, ex_jalr_taken;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_regwrite, mem_memread, mem_memwrite;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_regwrite;

    logic [1:0]            forward_a, forward_b;
    logic                  fwd_id_a, fwd_id_b;
    logic                  pc_write, ifid_write, idex_write, exmem_write;
    logic                  ifid_flush, idex_flush, memwb_bubble;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch, id_branch_taken,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_jalr_taken,
               mem_rd, mem_regwrite, mem_memread, mem_memwrite, wb_rd, wb_regwrite,
        input  forward_a, forward_b, fwd_id_a, fwd_id_b,
               pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, memwb_bubble
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch, id_branch_taken,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_jalr_taken,
               mem_rd, mem_regwrite, mem_memread, mem_memwrite, wb_rd, wb_regwrite,
        output forward_a, forward_b, fwd_id_a, fwd_id_b,
               pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, memwb_bubble
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// One source register against the EX/MEM and MEM/WB destinations; MEM wins, x0 never matches.
// Combinational, zero latency; no flow control.
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_regwrite_i,
    input  logic                  mem_memread_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_regwrite_i,
    output fwd_sel_e              sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        // A load in MEM has no ALU result to hand over yet.
        if (mem_regwrite_i && !mem_memread_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, stalls, flushes, data-memory wait, perf counters.
// All controls combinational from current inputs and FSM state; only the FSM and counters are registered.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int              CW       = lat_cnt_w(MEM_LAT);
    localparam int              LOAD_I   = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
    localparam logic [CW-1:0]   LOAD     = LOAD_I[CW-1:0];
    localparam bit              HAS_LAT  = (MEM_LAT > 0);

    fwd_sel_e   sel_ex_a, sel_ex_b, sel_id_a, sel_id_b;
    mem_state_e state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic trigger, mem_stall, lu, bo, bo_a, bo_b;
    logic pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_ex_a (
        .rs_i(hz.ex_rs1), .mem_rd_i(hz.mem_rd), .mem_regwrite_i(hz.mem_regwrite),
        .mem_memread_i(hz.mem_memread), .wb_rd_i(hz.wb_rd), .wb_regwrite_i(hz.wb_regwrite),
        .sel_o(sel_ex_a));
    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_ex_b (
        .rs_i(hz.ex_rs2), .mem_rd_i(hz.mem_rd), .mem_regwrite_i(hz.mem_regwrite),
        .mem_memread_i(hz.mem_memread), .wb_rd_i(hz.wb_rd), .wb_regwrite_i(hz.wb_regwrite),
        .sel_o(sel_ex_b));
    // The decode comparator only has a bypass from EX/MEM, so WB matching is disabled here.
    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_id_a (
        .rs_i(hz.id_rs1), .mem_rd_i(hz.mem_rd), .mem_regwrite_i(hz.mem_regwrite),
        .mem_memread_i(hz.mem_memread), .wb_rd_i(hz.wb_rd), .wb_regwrite_i(1'b0),
        .sel_o(sel_id_a));
    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_id_b (
        .rs_i(hz.id_rs2), .mem_rd_i(hz.mem_rd), .mem_regwrite_i(hz.mem_regwrite),
        .mem_memread_i(hz.mem_memread), .wb_rd_i(hz.wb_rd), .wb_regwrite_i(1'b0),
        .sel_o(sel_id_b));

    assign hz.forward_a = sel_ex_a;
    assign hz.forward_b = sel_ex_b;
    assign hz.fwd_id_a  = hz.id_uses_rs1 && (sel_id_a == FWD_MEM);
    assign hz.fwd_id_b  = hz.id_uses_rs2 && (sel_id_b == FWD_MEM);

    assign lu = hz.ex_memread && (hz.ex_rd != '0) &&
                ((hz.id_uses_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                 (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

    assign bo_a = hz.id_uses_rs1 && (hz.id_rs1 != '0) &&
                  ((hz.ex_regwrite && (hz.ex_rd == hz.id_rs1)) ||
                   (hz.mem_memread && (hz.mem_rd == hz.id_rs1)));
    assign bo_b = hz.id_uses_rs2 && (hz.id_rs2 != '0) &&
                  ((hz.ex_regwrite && (hz.ex_rd == hz.id_rs2)) ||
                   (hz.mem_memread && (hz.mem_rd == hz.id_rs2)));
    assign bo   = hz.id_is_branch && (bo_a || bo_b);

    assign trigger = enable_i && HAS_LAT && (hz.mem_memread || hz.mem_memwrite);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mem_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    mem_stall = 1'b1;
                    state_d   = ST_WAIT;
                    count_d   = LOAD;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (enable_i) begin
                    if (count_q == '0) state_d = ST_DONE;
                    else               count_d = count_q - CW'(1);
                end
            end
            // One release cycle so the access still sitting in MEM does not re-trigger.
            ST_DONE: begin
                if (enable_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (mem_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (hz.ex_jalr_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu || bo) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (hz.id_branch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.ifid_write   = ifid_write;
    assign hz.idex_write   = idex_write;
    assign hz.exmem_write  = exmem_write;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_flush   = idex_flush;
    assign hz.memwb_bubble = memwb_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (enable_i) begin
            if (!pc_write && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
            if ((ifid_flush || idex_flush) && (flush_q != {CNT_W{1'b1}}))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_LAT=3, CNT_W=4) with a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int LAT  = 3;
    localparam int MAXC = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic [3:0] stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_on = 1'b0;

    // Model state: remaining stall cycles of an access, and the release cycle after it.
    int m_busy;
    bit m_release;
    int m_stall, m_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .hz(hz),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] m_fsel(input logic [4:0] rs);
        if (rs != 5'd0 && hz.mem_regwrite && !hz.mem_memread && hz.mem_rd == rs) return 2'b01;
        if (rs != 5'd0 && hz.wb_regwrite && hz.wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_hit(input logic [4:0] r);
        return (r != 5'd0) && ((hz.ex_regwrite && hz.ex_rd == r) || (hz.mem_memread && hz.mem_rd == r));
    endfunction

    function automatic bit m_trig();
        return enable && (hz.mem_memread || hz.mem_memwrite) && (m_busy == 0) && !m_release;
    endfunction

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble}
    function automatic logic [6:0] exp_ctl();
        bit lu, bo;
        lu = hz.ex_memread && hz.ex_rd != 5'd0 &&
             ((hz.id_uses_rs1 && hz.ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && hz.ex_rd == hz.id_rs2));
        bo = hz.id_is_branch &&
             ((hz.id_uses_rs1 && m_hit(hz.id_rs1)) || (hz.id_uses_rs2 && m_hit(hz.id_rs2)));
        if (m_busy > 0 || m_trig()) return 7'b0000001;
        if (hz.ex_jalr_taken)       return 7'b1111110;
        if (lu || bo)               return 7'b0011010;
        if (hz.id_branch_taken)     return 7'b1111100;
        return 7'b1111000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_release <= 1'b0; m_stall <= 0; m_flush <= 0;
        end else if (enable) begin
            if ((exp_ctl() & 7'h40) == 7'h00 && m_stall < MAXC) m_stall <= m_stall + 1;
            if ((exp_ctl() & 7'h06) != 7'h00 && m_flush < MAXC) m_flush <= m_flush + 1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) m_release <= 1'b1;
            end else if (m_release) begin
                m_release <= 1'b0;
            end else if (m_trig()) begin
                m_busy <= LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_forward_a", hz.forward_a, m_fsel(hz.ex_rs1));
            chk("cyc_forward_b", hz.forward_b, m_fsel(hz.ex_rs2));
            chk("cyc_fwd_id_a", hz.fwd_id_a, hz.id_uses_rs1 && m_fsel(hz.id_rs1) == 2'b01);
            chk("cyc_fwd_id_b", hz.fwd_id_b, hz.id_uses_rs2 && m_fsel(hz.id_rs2) == 2'b01);
            chk("cyc_ctl", {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
                            hz.ifid_flush, hz.idex_flush, hz.memwb_bubble}, exp_ctl());
            chk("cyc_stall_cnt", stall_cnt, m_stall);
            chk("cyc_flush_cnt", flush_cnt, m_flush);
        end
    end

    task automatic clear();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
        hz.id_is_branch = 0; hz.id_branch_taken = 0;
        hz.ex_rs1 = '0; hz.ex_rs2 = '0; hz.ex_rd = '0;
        hz.ex_regwrite = 0; hz.ex_memread = 0; hz.ex_jalr_taken = 0;
        hz.mem_rd = '0; hz.mem_regwrite = 0; hz.mem_memread = 0; hz.mem_memwrite = 0;
        hz.wb_rd = '0; hz.wb_regwrite = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_lu();
        hz.ex_memread = 1; hz.ex_regwrite = 1; hz.ex_rd = 5'd6;
        hz.id_rs1 = 5'd6; hz.id_uses_rs1 = 1;
    endtask

    initial begin
        clear();
        enable = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        settle();
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_flush_cnt", flush_cnt, 0);
        chk("reset_pc_write", hz.pc_write, 1);
        step();
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Forwarding
        hz.mem_rd = 5'd5; hz.mem_regwrite = 1; hz.wb_rd = 5'd9; hz.wb_regwrite = 1;
        hz.ex_rs1 = 5'd5; hz.ex_rs2 = 5'd9;
        settle(); chk("fwd_mem_a", hz.forward_a, 1); chk("fwd_wb_b", hz.forward_b, 2);
        step();
        hz.wb_rd = 5'd5; hz.ex_rs2 = 5'd5;
        settle(); chk("fwd_prio_a", hz.forward_a, 1); chk("fwd_prio_b", hz.forward_b, 1);
        step();
        hz.mem_rd = 5'd0; hz.wb_rd = 5'd0; hz.ex_rs1 = 5'd0; hz.ex_rs2 = 5'd0;
        settle(); chk("fwd_x0_a", hz.forward_a, 0); chk("fwd_x0_b", hz.forward_b, 0);
        step(); clear();

        // Load-use
        set_lu();
        settle();
        chk("lu_pc_write", hz.pc_write, 0); chk("lu_ifid_write", hz.ifid_write, 0);
        chk("lu_idex_flush", hz.idex_flush, 1); chk("lu_stall_before", stall_cnt, 0);
        step();
        hz.ex_memread = 0;
        settle(); chk("lu_released", hz.pc_write, 1); chk("lu_stall_after", stall_cnt, 1);
        step(); clear();

        // Branch operand hazard, then ID forwarding with a taken branch
        hz.id_is_branch = 1; hz.id_uses_rs1 = 1; hz.id_rs1 = 5'd7;
        hz.ex_rd = 5'd7; hz.ex_regwrite = 1; hz.id_branch_taken = 1;
        settle();
        chk("bo_pc_write", hz.pc_write, 0); chk("bo_ifid_flush", hz.ifid_flush, 0);
        chk("bo_idex_flush", hz.idex_flush, 1);
        step();
        hz.ex_rd = 5'd0; hz.ex_regwrite = 0; hz.mem_rd = 5'd7; hz.mem_regwrite = 1;
        settle();
        chk("br_fwd_id_a", hz.fwd_id_a, 1); chk("br_pc_write", hz.pc_write, 1);
        chk("br_ifid_flush", hz.ifid_flush, 1); chk("br_flush_before", flush_cnt, 2);
        step(); clear();
        settle(); chk("br_flush_after", flush_cnt, 3); chk("br_stall_after", stall_cnt, 2);
        step();

        // JALR overrides load-use
        set_lu(); hz.ex_jalr_taken = 1;
        settle();
        chk("jalr_lu_pc_write", hz.pc_write, 1); chk("jalr_lu_ifid_flush", hz.ifid_flush, 1);
        chk("jalr_lu_idex_flush", hz.idex_flush, 1);
        step(); clear();

        // Memory wait with a pending JALR
        rst_n = 1'b0; #1;
        chk("rst_mid_stall_cnt", stall_cnt, 0);
        step(); rst_n = 1'b1;
        hz.mem_memread = 1; hz.mem_rd = 5'd8; hz.mem_regwrite = 1; hz.ex_jalr_taken = 1;
        for (int i = 0; i < LAT + 1; i++) begin
            settle();
            chk("mw_pc_write", hz.pc_write, 0); chk("mw_bubble", hz.memwb_bubble, 1);
            chk("mw_ifid_flush", hz.ifid_flush, 0);
            step();
        end
        settle();
        chk("mw_done_pc_write", hz.pc_write, 1); chk("mw_done_bubble", hz.memwb_bubble, 0);
        chk("mw_done_ifid_flush", hz.ifid_flush, 1); chk("mw_done_idex_flush", hz.idex_flush, 1);
        step(); clear();
        settle(); chk("mw_stall_cnt", stall_cnt, 4); chk("mw_flush_cnt", flush_cnt, 1);

        // Enable low freezes WAIT and counters; reset inside WAIT abandons the access
        step();
        hz.mem_memread = 1;
        step();
        enable = 1'b0;
        settle(); chk("en0_wait_stall", hz.pc_write, 0);
        step(); step();
        settle(); chk("en0_stall_hold", stall_cnt, 5);
        enable = 1'b1; rst_n = 1'b0; #1;
        chk("rst_wait_stall_cnt", stall_cnt, 0);
        chk("rst_wait_idle_trig", hz.pc_write, 0);
        clear(); #1;
        chk("rst_wait_normal", hz.pc_write, 1);
        chk("rst_wait_bubble", hz.memwb_bubble, 0);
        step(); rst_n = 1'b1;

        // Counter saturation
        set_lu();
        repeat (20) step();
        settle();
        chk("sat_stall_cnt", stall_cnt, 15); chk("sat_flush_cnt", flush_cnt, 15);
        enable = 1'b0;
        step();
        settle(); chk("sat_en0_pc_write", hz.pc_write, 0); chk("sat_en0_cnt", stall_cnt, 15);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
